// File: rtl/qed_dup_encoder.sv
// qed_dup_encoder: emits re-encoded originals and buffers register-remapped duplicates for later drain
module qed_dup_encoder #(
  parameter int DEPTH = 8,
  parameter int REG_OFFSET = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     is_lw,
  input  logic                     is_sw,
  input  logic                     is_aluimm,
  input  logic                     is_aluimm_64,
  input  logic                     is_alureg,
  input  logic [6:0]               opcode,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [5:0]               funct7_64,
  input  logic [5:0]               shamt_64,
  input  logic [11:0]              simm12,
  input  logic                     flush_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic                     out_is_dup,
  output logic [$clog2(DEPTH):0]   dup_pending,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [5:0] OFS = 6'(REG_OFFSET);
  typedef enum logic {ORIG, DRAIN} state_t;
  state_t state_q;
  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic out_valid_q, out_is_dup_q, err_q;
  logic [31:0] out_instr_q;
  logic c_lw, c_sw, c_reg, c_imm, use_rd, use_rs2, legal;
  logic slot_free, accept, push, pop;
  logic [4:0] rd_m, rs1_m, rs2_m;
  logic [11:0] hi_base, hi_o, hi_d;
  logic [31:0] orig_w, dup_w;

  function automatic logic [4:0] remap(input logic [4:0] r);
    return (r == 5'd0) ? r : r + 5'(REG_OFFSET);
  endfunction

  function automatic logic big(input logic [4:0] r);
    return {1'b0, r} >= OFS;
  endfunction

  // Class decode in priority order lw > sw > alureg > aluimm, plus both encodings
  always_comb begin
    c_lw    = is_lw;
    c_sw    = !is_lw && is_sw;
    c_reg   = !is_lw && !is_sw && is_alureg;
    c_imm   = !is_lw && !is_sw && !is_alureg && is_aluimm;
    use_rd  = c_lw || c_reg || c_imm;
    use_rs2 = c_sw || c_reg;
    legal   = (c_lw || c_sw || c_reg || c_imm) && !big(rs1)
              && !(use_rd && big(rd)) && !(use_rs2 && big(rs2));
    rd_m    = use_rd ? remap(rd) : rd;
    rs1_m   = remap(rs1);
    rs2_m   = remap(rs2);
    hi_base = (c_imm && is_aluimm_64) ? {funct7_64, shamt_64} : simm12;
    hi_o    = use_rs2 ? {funct7, rs2} : hi_base;
    hi_d    = use_rs2 ? {funct7, rs2_m} : hi_base;
    orig_w  = {hi_o, rs1, funct3, rd, opcode};
    dup_w   = {hi_d, rs1_m, funct3, rd_m, opcode};
  end

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == ORIG) && slot_free && (cnt_q < CW'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = (state_q == DRAIN) && slot_free && (cnt_q != '0);
  assign cnt_d     = cnt_q + CW'(push) - CW'(pop);

  // Duplicate storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= dup_w;
  end

  // Control FSM, output register, FIFO pointers and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ORIG;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_is_dup_q <= 1'b0;
      err_q        <= 1'b0;
      wp_q         <= '0;
      rp_q         <= '0;
      cnt_q        <= '0;
    end else begin
      if (slot_free) out_valid_q <= push || pop;
      if (push) begin
        out_instr_q  <= orig_w;
        out_is_dup_q <= 1'b0;
        wp_q         <= wp_q + AW'(1);
      end
      if (pop) begin
        out_instr_q  <= mem_q[rp_q];
        out_is_dup_q <= 1'b1;
        rp_q         <= rp_q + AW'(1);
      end
      cnt_q <= cnt_d;
      if (accept && !legal) err_q <= 1'b1;
      if (state_q == ORIG) state_q <= (cnt_d == CW'(DEPTH) || (flush_req && cnt_d != '0)) ? DRAIN : ORIG;
      else state_q <= (cnt_d == '0) ? ORIG : DRAIN;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_is_dup  = out_is_dup_q;
  assign dup_pending = cnt_q;
  assign err         = err_q;
endmodule

// File: tb/tb_qed_dup_encoder.sv
// tb_qed_dup_encoder: directed and randomized checks of qed_dup_encoder against a queue-based model
module tb_qed_dup_encoder;
  localparam int DEPTH = 8;
  localparam int OFS = 16;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready;
  logic is_lw = 0, is_sw = 0, is_aluimm = 0, is_aluimm_64 = 0, is_alureg = 0;
  logic [6:0] opcode = 0, funct7 = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [2:0] funct3 = 0;
  logic [5:0] funct7_64 = 0, shamt_64 = 0;
  logic [11:0] simm12 = 0;
  logic flush_req = 0, out_valid, out_ready = 1, out_is_dup, err;
  logic [31:0] out_instr;
  logic [3:0] dup_pending;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  qed_dup_encoder #(.DEPTH(DEPTH), .REG_OFFSET(OFS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .is_lw(is_lw), .is_sw(is_sw), .is_aluimm(is_aluimm), .is_aluimm_64(is_aluimm_64),
    .is_alureg(is_alureg), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .funct7_64(funct7_64), .shamt_64(shamt_64),
    .simm12(simm12), .flush_req(flush_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_is_dup(out_is_dup), .dup_pending(dup_pending), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending duplicates in a queue, output slot as plain variables
  logic [31:0] dq[$];
  bit m_drain, m_ov, m_dup, m_err, chk_en;
  logic [31:0] m_instr;
  bit ms_slot, ms_ir, ms_acc, ms_lg, ms_push, ms_pop;

  function automatic int cls();
    if (is_lw) return 1;
    if (is_sw) return 2;
    if (is_alureg) return 3;
    if (is_aluimm) return 4;
    return 0;
  endfunction

  function automatic bit mlegal();
    int c = cls();
    if (c == 0 || rs1 >= OFS) return 0;
    if (c != 2 && rd >= OFS) return 0;
    if ((c == 2 || c == 3) && rs2 >= OFS) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] menc(input bit dup);
    int c = cls();
    logic [31:0] d = 32'(rd), s1 = 32'(rs1), s2 = 32'(rs2), lo;
    if (dup) begin
      if (s1 != 0) s1 += OFS;
      if (c != 2 && d != 0) d += OFS;
      if ((c == 2 || c == 3) && s2 != 0) s2 += OFS;
    end
    lo = (s1 << 15) | (32'(funct3) << 12) | (d << 7) | 32'(opcode);
    if (c == 2 || c == 3) return (32'(funct7) << 25) | (s2 << 20) | lo;
    if (c == 4 && is_aluimm_64) return (32'(funct7_64) << 26) | (32'(shamt_64) << 20) | lo;
    return (32'(simm12) << 20) | lo;
  endfunction

  function automatic bit m_ir_exp();
    return !m_drain && (!m_ov || out_ready) && dq.size() < DEPTH;
  endfunction

  // Advance the model on every rising edge using the inputs held across it
  always @(posedge clk) begin
    if (rst) begin
      dq.delete();
      m_drain = 0; m_ov = 0; m_dup = 0; m_instr = 0; m_err = 0;
    end else begin
      ms_slot = !m_ov || out_ready;
      ms_ir   = m_ir_exp();
      ms_acc  = in_valid && ms_ir;
      ms_lg   = mlegal();
      ms_push = ms_acc && ms_lg;
      ms_pop  = m_drain && ms_slot && dq.size() > 0;
      if (ms_slot) begin
        m_ov = ms_push || ms_pop;
        if (ms_push) begin m_instr = menc(0); m_dup = 0; end
        else if (ms_pop) begin m_instr = dq.pop_front(); m_dup = 1; end
      end
      if (ms_push) dq.push_back(menc(1));
      if (ms_acc && !ms_lg) m_err = 1;
      if (!m_drain) m_drain = dq.size() == DEPTH || (flush_req && dq.size() > 0);
      else m_drain = dq.size() > 0;
    end
  end

  // Compare DUT to the model mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_ir_exp()));
      chk("dup_pending", 32'(dup_pending), 32'(dq.size()));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("err", 32'(err), 32'(m_err));
      if (m_ov) begin
        chk("out_instr", out_instr, m_instr);
        chk("out_is_dup", 32'(out_is_dup), 32'(m_dup));
      end
    end
  end

  logic [31:0] seen_i[$];
  bit seen_d[$];
  bit mon_en = 0;
  always @(negedge clk) if (mon_en && out_valid && out_ready) begin
    seen_i.push_back(out_instr);
    seen_d.push_back(out_is_dup);
  end

  // f = {lw, sw, alureg, aluimm, aluimm_64}
  task automatic drive(input logic [4:0] f, input logic [6:0] op, input logic [4:0] d, s1, s2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [11:0] imm, input bit fl);
    {is_lw, is_sw, is_alureg, is_aluimm, is_aluimm_64} = f;
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; simm12 = imm;
    funct7_64 = 0; shamt_64 = 0; flush_req = fl; in_valid = 1;
  endtask

  task automatic send(input logic [4:0] f, input logic [6:0] op, input logic [4:0] d, s1, s2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [11:0] imm, input bit fl);
    drive(f, op, d, s1, s2, f3, f7, imm, fl);
    @(posedge clk); #1;
    in_valid = 0; flush_req = 0;
  endtask

  task automatic get(input string name, input logic [31:0] ei, input bit ed);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk({name, " valid"}, 32'(out_valid), 1);
    chk({name, " instr"}, out_instr, ei);
    chk({name, " dup"}, 32'(out_is_dup), 32'(ed));
    @(posedge clk); #1;
  endtask

  logic [4:0] fl_tab [6] = '{5'd0, 5'd16, 5'd8, 5'd4, 5'd2, 5'd3};

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_instr", out_instr, 0);
    chk("rst out_is_dup", 32'(out_is_dup), 0);
    chk("rst err", 32'(err), 0);
    chk("rst dup_pending", 32'(dup_pending), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    rst = 0; chk_en = 1;

    // add x3,x1,x2 with flush; first pin the model encoder
    drive(5'd4, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 1);
    chk("model add orig", menc(0), 32'h002081B3);
    chk("model add dup", menc(1), 32'h012889B3);
    in_valid = 0; flush_req = 0;
    send(5'd4, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 1);
    get("add orig", 32'h002081B3, 0);
    get("add dup", 32'h012889B3, 1);

    send(5'd16, 7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 12'd8, 1);
    get("lw orig", 32'h00812283, 0);
    get("lw dup", 32'h00892A83, 1);

    send(5'd2, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 1);
    get("nop orig", 32'h00000013, 0);
    get("nop dup", 32'h00000013, 1);

    // 8 back-to-back addi xi,xi,i fill the FIFO
    seen_i.delete(); seen_d.delete(); mon_en = 1;
    for (int i = 1; i <= 8; i++) begin
      drive(5'd2, 7'h13, 5'(i), 5'(i), 5'd0, 3'd0, 7'd0, 12'(i), 0);
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(negedge clk);
    chk("full in_ready", 32'(in_ready), 0);
    chk("full pending", 32'(dup_pending), 8);
    repeat (12) @(posedge clk);
    @(negedge clk);
    mon_en = 0;
    chk("drained pending", 32'(dup_pending), 0);
    chk("drained in_ready", 32'(in_ready), 1);
    chk("stream size", 32'(seen_i.size()), 16);
    if (seen_i.size() == 16) begin
      chk("stream first", seen_i[0], 32'h00108093);
      chk("stream 8th orig flag", 32'(seen_d[7]), 0);
      chk("stream first dup", seen_i[8], 32'h00188893);
      chk("stream last dup", seen_i[15], 32'h008C0C13);
      chk("stream last flag", 32'(seen_d[15]), 1);
    end

    // illegal inputs are consumed silently and set a sticky err
    send(5'd4, 7'h33, 5'd17, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 0);
    repeat (3) begin @(negedge clk); chk("illegal no out", 32'(out_valid), 0); end
    chk("illegal err", 32'(err), 1);
    send(5'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 0);
    @(negedge clk);
    chk("noclass no out", 32'(out_valid), 0);
    chk("noclass pending", 32'(dup_pending), 0);
    send(5'd16, 7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 12'd8, 1);
    get("post-err lw orig", 32'h00812283, 0);
    get("post-err lw dup", 32'h00892A83, 1);
    chk("err sticky", 32'(err), 1);

    // stall mid-drain, then reset during DRAIN
    for (int i = 1; i <= 4; i++) send(5'd2, 7'h13, 5'(i), 5'(i), 5'd0, 3'd0, 7'd0, 12'(i), i == 4);
    @(posedge clk); #1;
    out_ready = 0;
    repeat (5) begin
      @(negedge clk);
      chk("stall instr", out_instr, 32'h00188893);
      chk("stall dup", 32'(out_is_dup), 1);
      chk("stall pending", 32'(dup_pending), 3);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("mid rst out_valid", 32'(out_valid), 0);
    chk("mid rst out_instr", out_instr, 0);
    chk("mid rst out_is_dup", 32'(out_is_dup), 0);
    chk("mid rst pending", 32'(dup_pending), 0);
    chk("mid rst err", 32'(err), 0);
    chk("mid rst in_ready", 32'(in_ready), 1);
    out_ready = 1;

    // randomized traffic; the compare process checks every cycle
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      begin
        int r = int'($urandom_range(0, 11));
        {is_lw, is_sw, is_alureg, is_aluimm, is_aluimm_64} = r < 6 ? fl_tab[r] : 5'($urandom);
      end
      rd  = ($urandom % 20 < 18) ? 5'($urandom % 16) : 5'($urandom);
      rs1 = ($urandom % 20 < 18) ? 5'($urandom % 16) : 5'($urandom);
      rs2 = ($urandom % 20 < 18) ? 5'($urandom % 16) : 5'($urandom);
      opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      funct7_64 = 6'($urandom); shamt_64 = 6'($urandom); simm12 = 12'($urandom);
      in_valid = 1'($urandom % 2);
      out_ready = ($urandom % 4) != 0;
      flush_req = ($urandom % 10) == 0;
      rst = ($urandom % 600) == 0;
    end
    @(posedge clk); #1;
    rst = 0; in_valid = 0; flush_req = 0; out_ready = 1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qed_dup_encoder.md
Name: qed_dup_encoder

Overview:
- Re-encodes decoded RV64G instruction fields into 32-bit instruction words for the core fetch path in the SQED harness.
- Each accepted instruction is emitted as an original, and its register-remapped duplicate is buffered in a FIFO.
- When the FIFO fills, or a flush is requested, the block drains the buffered duplicates before accepting new originals.
- Only lw/sw (incl. FP load/store), alureg (incl. FP ops) and aluimm classes are supported.

Parameters:
DEPTH, 8, duplicate FIFO depth (power of 2, >=2)
REG_OFFSET, 16, register index offset added for duplicates

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  decoded fields valid
in_ready  output  1  block accepts fields this cycle
is_lw  input  1  load class
is_sw  input  1  store class
is_aluimm  input  1  ALU-immediate class
is_aluimm_64  input  1  RV64 shift-immediate (with is_aluimm)
is_alureg  input  1  ALU-register class
opcode  input  7  opcode field
rd  input  5  destination / imm5 source for stores
rs1  input  5  source 1
rs2  input  5  source 2
funct3  input  3  funct3
funct7  input  7  funct7 / simm7 for stores
funct7_64  input  6  RV64 shift funct
shamt_64  input  6  RV64 shift amount
simm12  input  12  I-type immediate
flush_req  input  1  drain pending duplicates now
out_valid  output  1  out_instr valid
out_ready  input  1  consumer takes out_instr
out_instr  output  32  encoded instruction
out_is_dup  output  1  out_instr is a duplicate
dup_pending  output  $clog2(DEPTH)+1  FIFO occupancy
err  output  1  sticky illegal-input flag

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_is_dup=0, err=0, dup_pending=0, state=ORIG.
- Encoding: the first matching class below is used, in priority order lw > sw > alureg > aluimm_64 > aluimm.
  - lw: {simm12, rs1, funct3, rd, opcode}
  - sw: {funct7, rs2, rs1, funct3, rd, opcode}
  - alureg: {funct7, rs2, rs1, funct3, rd, opcode}
  - aluimm with is_aluimm_64: {funct7_64, shamt_64, rs1, funct3, rd, opcode}
  - aluimm otherwise: {simm12, rs1, funct3, rd, opcode}
- Duplicate encoding: identical to the original, except every register field actually used by the class gets REG_OFFSET added.
  - Remapped fields: rd for lw/alureg/aluimm; rs1 for all classes; rs2 for sw/alureg.
  - Index 0 is never remapped.
  - The sw imm5 field (rd position) is not remapped.
  - Immediates are unchanged.
- Illegal input: no class flag set, or any used register field >= REG_OFFSET.
  - The input is consumed (handshake completes), nothing is emitted and nothing is pushed.
  - err is set and stays 1 until rst.
- Output register: out_valid/out_instr/out_is_dup hold until out_ready. slot_free = !out_valid || out_ready.
- State ORIG:
  - in_ready = slot_free && dup_pending < DEPTH.
  - On a legal accept: next cycle out_valid=1, out_instr=original, out_is_dup=0; the duplicate is pushed into the FIFO in the same cycle.
  - Transition to DRAIN when the post-update occupancy == DEPTH.
  - Transition to DRAIN when flush_req=1 and the post-update occupancy > 0.
  - flush_req with an empty FIFO has no effect.
  - A simultaneous accept and flush_req does both: accept, push, then DRAIN.
- State DRAIN:
  - in_ready=0.
  - When slot_free, pop the FIFO head into the output register with out_is_dup=1, in FIFO order.
  - Return to ORIG in the cycle the last entry is popped.
  - flush_req is ignored.
- Latency: 1 cycle from accept (or pop) to out_valid. Full throughput of 1 instruction/cycle when out_ready=1.
- FIFO pointers wrap modulo DEPTH; no overflow or underflow is reachable.
- rst mid-operation discards FIFO contents and the output register.

Test Plan:
- add x3,x1,x2 (alureg, funct7=0, rs2=2, rs1=1, funct3=0, rd=3, opcode=0x33), then flush_req → 0x002081B3 (is_dup=0), then 0x012889B3 (is_dup=1).
- lw x5,8(x2) (simm12=8, funct3=2) + flush → 0x00812283, then 0x00892A83.
- addi x0,x0,0 → original 0x00000013 and duplicate 0x00000013 (x0 not remapped).
- 8 back-to-back legal instructions with out_ready=1 → 8 originals; in_ready=0 after the 8th; 8 duplicates in order; then back to ORIG with dup_pending=0.
- rd=17 or no class flag → input consumed, no output, err=1; a later legal input still works and err stays 1.
- out_ready=0 for 5 cycles mid-drain → out_instr stable, no pop, dup_pending unchanged; rst asserted during DRAIN → all outputs 0, state ORIG.
